mac_feeder: RTL

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_feeder_if.sv | 23 ++
 rtl/mac_operand_fifo.sv | 69 ++++++
 rtl/mac_feeder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC operand feeder.
// Operand pairs travel as one packed word so the buffer stays width-agnostic.
package mac_pkg;

  localparam int OP_W        = 16;
  localparam int ACC_W       = 32;
  localparam int DEPTH_DEF   = 8;
  localparam int DRAIN_DEF   = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_STREAM = 3'd1;
  localparam state_t ST_DRAIN  = 3'd2;
  localparam state_t ST_FINAL  = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;

  typedef struct packed {
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/mac_feeder_if.sv
// Feeder-to-MAC link: operand/enable/finalize out, accumulated result and strobe back.
// Master is the feeder, slave is the MAC datapath.
interface mac_feeder_if;
  import mac_pkg::*;

  logic                    mac_en;
  logic                    mac_finalize;
  logic signed [OP_W-1:0]  mac_a;
  logic signed [OP_W-1:0]  mac_b;
  logic signed [ACC_W-1:0] mac_out;
  logic                    mac_out_valid;

  modport master (
    output mac_en, mac_finalize, mac_a, mac_b,
    input  mac_out, mac_out_valid
  );

  modport slave (
    input  mac_en, mac_finalize, mac_a, mac_b,
    output mac_out, mac_out_valid
  );

endinterface

// File: rtl/mac_operand_fifo.sv
// Single-clock FIFO with registered count/full/empty; head word readable without latency.
// Writes when full and reads when empty are dropped; clr empties it in one cycle.
module mac_operand_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (wr_ok && !rd_ok)
      count_nxt = count + 1'b1;
    else if (rd_ok && !wr_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr)
      mem[wr_ptr] <= wr_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Buffers operand pairs, then streams them into a MAC, drains, finalizes and captures the result.
// One pair per cycle while streaming; loads accepted only when idle and not full; result wait is time-bounded.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int DRAIN_CYCLES = DRAIN_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic signed [OP_W-1:0]  wr_a,
  input  logic signed [OP_W-1:0]  wr_b,
  output logic                    full,
  input  logic                    start,
  output logic                    busy,
  output logic signed [ACC_W-1:0] result,
  output logic                    done,
  output logic                    timeout_err,
  mac_feeder_if.master            mac
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);

  state_t        state;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] wcnt;
  logic [CW-1:0] count;
  logic          empty;
  pair_t         wr_pair;
  pair_t         head;
  logic          push;
  logic          take;
  logic          clr;
  logic          timeout_hit;

  assign wr_pair     = '{a: wr_a, b: wr_b};
  assign push        = wr_en && (state == ST_IDLE);
  assign take        = ((state == ST_IDLE) && start && (count != '0)) ||
                       ((state == ST_STREAM) && !empty);
  // Finalize drops at the first WAIT edge, so TIMEOUT-1 WAIT edges put done TIMEOUT cycles after it.
  assign timeout_hit = (wcnt == TW'(TIMEOUT - 2));
  assign clr         = (state == ST_WAIT) && (mac.mac_out_valid || timeout_hit);

  mac_operand_fifo #(
    .W     ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .wr_en  (push),
    .wr_dat (wr_pair),
    .rd_en  (take),
    .rd_dat (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac.mac_en <= 1'b0;
      mac.mac_a  <= '0;
      mac.mac_b  <= '0;
    end else if (take) begin
      mac.mac_en <= 1'b1;
      mac.mac_a  <= head.a;
      mac.mac_b  <= head.b;
    end else if (state == ST_STREAM) begin
      mac.mac_en <= 1'b0;
      mac.mac_a  <= '0;
      mac.mac_b  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      dcnt             <= '0;
      wcnt             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
      result           <= '0;
      mac.mac_finalize <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            timeout_err <= 1'b0;
            if (take) begin
              state <= ST_STREAM;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (!take) begin
            state <= ST_DRAIN;
            dcnt  <= '0;
          end
        end
        ST_DRAIN: begin
          if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
            state            <= ST_FINAL;
            mac.mac_finalize <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_FINAL: begin
          mac.mac_finalize <= 1'b0;
          state            <= ST_WAIT;
          wcnt             <= '0;
        end
        ST_WAIT: begin
          if (mac.mac_out_valid) begin
            result <= mac.mac_out;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
